// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, requests instruction memory and hands one
// registered word per cycle to decode. Optional macro IF_FETCH_CNT_EN adds fetch_count.
module if_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]         NOP_WORD = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ready,
  input  logic                id_ready,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [31:0]         instruction,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                inst_valid,
  output logic                halted
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0]         fetch_count
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  state_t              r_state;
  state_t              w_nextState;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_pcOut;
  logic [31:0]         r_inst;
  logic                r_valid;
  logic                w_capture;
  logic                w_consume;
  logic                w_isSystem;

  // A new word is only requested when the slot is empty or drains this cycle.
  assign imem_req   = (r_state == FETCH) && (!r_valid || id_ready);
  assign imem_addr  = r_pc;
  assign w_capture  = imem_req && imem_ready && !branch_taken;
  assign w_consume  = r_valid && id_ready;
  assign w_isSystem = (imem_rdata[6:0] == OPC_SYSTEM);

  assign instruction = r_inst;
  assign pc_out      = r_pcOut;
  assign inst_valid  = r_valid;
  assign halted      = (r_state == HALT);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      BOOT:    w_nextState = FETCH;
      FETCH:   if (!branch_taken && w_capture && w_isSystem) w_nextState = HALT;
      HALT:    if (branch_taken) w_nextState = FETCH;
      default: w_nextState = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Redirect outranks capture, which outranks a plain consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_pcOut <= '0;
      r_inst  <= NOP_WORD;
      r_valid <= 1'b0;
    end else if (branch_taken) begin
      r_pc    <= branch_target;
      r_inst  <= NOP_WORD;
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_pc    <= r_pc + PC_WIDTH'(4);
      r_pcOut <= r_pc;
      r_inst  <= imem_rdata;
      r_valid <= 1'b1;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

`ifdef IF_FETCH_CNT_EN
  logic [31:0] r_fetchCount;

  assign fetch_count = r_fetchCount;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchCount <= '0;
    end else if (w_capture && (r_fetchCount != 32'hFFFFFFFF)) begin
      r_fetchCount <= r_fetchCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the fetch slot.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int M_BOOT  = 0;
  localparam int M_FETCH = 1;
  localparam int M_HALT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        id_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        halted;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int passes = 0;

  // Reference model: the PC, the one-entry output slot and the fetch mode.
  logic [31:0] mPc = '0;
  logic [31:0] mInst = NOP;
  logic [31:0] mPcOut = '0;
  logic        mValid = 1'b0;
  int          mMode = M_BOOT;
  logic [31:0] mCount = '0;

  if_stage #(.PC_WIDTH(32), .RESET_PC(32'h0), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .id_ready(id_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instruction(instruction), .pc_out(pc_out),
    .inst_valid(inst_valid), .halted(halted)
`ifdef IF_FETCH_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic modelReq(input logic idr);
    return (mMode == M_FETCH) && (!mValid || idr);
  endfunction

  // One clock cycle: drive inputs, check the request side, clock, check the slot.
  task automatic applyStimulus(input logic rs, input logic idr, input logic rdy,
                               input logic [31:0] data, input logic br,
                               input logic [31:0] tgt);
    logic req;
    @(negedge clk);
    req           = modelReq(idr);
    rst           = rs;
    id_ready      = idr;
    imem_ready    = rdy && req && !rs;
    imem_rdata    = data;
    branch_taken  = br;
    branch_target = tgt;
    #1;
    if (!rs) begin
      checkOutput("imem_req", {31'd0, imem_req}, {31'd0, req});
      checkOutput("imem_addr", imem_addr, mPc);
    end
    @(posedge clk);
    if (rs) begin
      mPc = '0; mInst = NOP; mPcOut = '0; mValid = 1'b0; mMode = M_BOOT; mCount = '0;
    end else if (mMode == M_BOOT) begin
      mMode = M_FETCH;
      if (br) mPc = tgt;
    end else if (br) begin
      mPc = tgt; mValid = 1'b0; mInst = NOP; mMode = M_FETCH;
    end else if (req && imem_ready) begin
      mInst = data; mPcOut = mPc; mValid = 1'b1; mPc = mPc + 32'd4;
      if (mCount != 32'hFFFFFFFF) mCount = mCount + 32'd1;
      if (data[6:0] == 7'h73) mMode = M_HALT;
    end else if (mValid && idr) begin
      mValid = 1'b0;
    end
    #1;
    checkOutput("instruction", instruction, mInst);
    checkOutput("pc_out", pc_out, mPcOut);
    checkOutput("inst_valid", {31'd0, inst_valid}, {31'd0, mValid});
    checkOutput("halted", {31'd0, halted}, {31'd0, mMode == M_HALT});
`ifdef IF_FETCH_CNT_EN
    checkOutput("fetch_count", fetch_count, mCount);
`endif
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] t;
    // Reset, boot bubble, then three back-to-back fetches.
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("reset_inst", instruction, NOP);
    applyStimulus(0, 1, 1, 32'h33, 0, 0);
    applyStimulus(0, 1, 1, 32'h33, 0, 0);
    checkOutput("first_pc", pc_out, 32'h0);
    applyStimulus(0, 1, 1, 32'h03, 0, 0);
    // Stall three cycles holding word 2.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 32'hdead, 0, 0);
    checkOutput("stall_hold", instruction, 32'h03);
    applyStimulus(0, 1, 0, 32'h23, 0, 0);
    applyStimulus(0, 1, 1, 32'h23, 0, 0);
    checkOutput("resume_pc", pc_out, 32'h8);
    // Branch coinciding with a response drops the response.
    applyStimulus(0, 1, 1, 32'h1234, 1, 32'h40);
    checkOutput("branch_addr", imem_addr, 32'h40);
    applyStimulus(0, 1, 1, 32'h33, 0, 0);
    // SYSTEM word halts fetch after being delivered.
    applyStimulus(0, 1, 1, 32'h0, 1, 32'h10);
    applyStimulus(0, 1, 1, 32'h73, 0, 0);
    checkOutput("sys_delivered", instruction, 32'h73);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 32'h33, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 32'h80);
    applyStimulus(0, 1, 1, 32'h13, 0, 0);
    checkOutput("after_halt_pc", pc_out, 32'h80);
    // PC wrap at the top of the address space.
    applyStimulus(0, 1, 0, 0, 1, 32'hFFFFFFFC);
    applyStimulus(0, 1, 1, 32'h33, 0, 0);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    // Reset arriving mid-stall.
    applyStimulus(0, 0, 1, 32'h03, 0, 0);
    applyStimulus(0, 0, 1, 32'h03, 0, 0);
    applyStimulus(1, 0, 1, 32'h03, 0, 0);
    applyStimulus(0, 1, 1, 32'h33, 0, 0);
    // Five captures, a branch, two captures: counter keeps running.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 32'h33 + i, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 32'h200);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 32'h33, 0, 0);
`ifdef IF_FETCH_CNT_EN
    checkOutput("count_seven", fetch_count, 32'd7);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("count_reset", fetch_count, 32'd0);
`endif
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      d = $urandom;
      if ($urandom_range(0, 15) == 0) d[6:0] = 7'h73;
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) != 0, d, $urandom_range(0, 11) == 0, t);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
